// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction fetch stage with a small in-order fetch buffer in front of the
// decode stage. The PC is word-addressed and advances by one per issued fetch.
// Instruction memory is a fixed one-cycle-latency read port: a request in
// cycle N returns imem_rdata in cycle N+1. That data is written into the
// buffer at the end of N+1 and reaches IF_ID_* in N+2.
//
// Fetches are issued only when a buffer slot is guaranteed for the response.
// The slot count includes the response still in flight and the entry that
// decode is popping this cycle. A redirect from EX/MEM overrides everything
// else in its cycle: it reloads the PC, empties the buffer, drops the pending
// response and issues no fetch.
//
// Handshake (IF -> ID): the head entry is offered while IF_ID_VALID=1. It is
// consumed on a rising edge where IF_ID_VALID=1 and id_ready=1, unless
// EX_MEM_PCSrc=1 in that same cycle. While it is not consumed, IF_ID_INSTR and
// IF_ID_NPC hold their values. The memory side has no ready signal:
// imem_req=1 is a committed read, and its data is taken exactly one cycle
// later.
//
// Parameters
//   WIDTH     : instruction / PC / NPC width in bits
//   ADDR_W    : instruction-memory word-address width (depth 2^ADDR_W)
//   BUF_DEPTH : fetch-buffer entries, 2..8
//   RESET_PC  : PC loaded on reset
//
// Ports
//   clk            : rising-edge clock
//   rst_n          : asynchronous active-low reset
//   EX_MEM_PCSrc   : redirect request
//   EX_MEM_NPC     : redirect target PC
//   imem_req       : memory read request this cycle
//   imem_addr      : memory word address, PC[ADDR_W-1:0] (aliases on wrap)
//   imem_rdata     : read data, valid one cycle after imem_req
//   id_ready       : decode accepts the head entry
//   IF_ID_VALID    : buffer head is valid
//   IF_ID_INSTR    : buffer head instruction
//   IF_ID_NPC      : buffer head next-PC tag (fetch PC + 1)
//   redirect_count : saturating count of accepted redirects
// -----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int              WIDTH     = 32,
    parameter int              ADDR_W    = 7,
    parameter int              BUF_DEPTH = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EX_MEM_PCSrc,
    input  logic [WIDTH-1:0]  EX_MEM_NPC,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [WIDTH-1:0]  imem_rdata,
    input  logic              id_ready,
    output logic              IF_ID_VALID,
    output logic [WIDTH-1:0]  IF_ID_INSTR,
    output logic [WIDTH-1:0]  IF_ID_NPC,
    output logic [15:0]       redirect_count
);

    // count must be able to hold BUF_DEPTH itself
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = $clog2(BUF_DEPTH);

    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] pc;
    logic             inflight;   // a response arrives on imem_rdata this cycle
    logic [WIDTH-1:0] tag_npc;    // NPC tag travelling with that response

    logic [WIDTH-1:0] fifo_instr [BUF_DEPTH];
    logic [WIDTH-1:0] fifo_npc   [BUF_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [15:0]      redir_cnt;

    // -------------------------------------------------------------------------
    // Control
    // -------------------------------------------------------------------------
    logic             redirect;
    logic             pop;
    logic             push;
    logic             issue;
    logic [CNT_W:0]   occupancy;
    logic [WIDTH-1:0] pc_inc;

    assign redirect = EX_MEM_PCSrc;
    assign pop      = (count != '0) & id_ready;
    assign push     = inflight;
    assign pc_inc   = pc + WIDTH'(1);

    // Slots already promised: buffered entries plus the pending response,
    // minus the head that leaves at this edge. pop implies count >= 1, so the
    // subtraction cannot underflow.
    assign occupancy = {1'b0, count}
                     + {{CNT_W{1'b0}}, inflight}
                     - {{CNT_W{1'b0}}, pop};

    // rst_n gates the request so the memory sees no read while reset is held.
    assign issue = rst_n & ~redirect & (occupancy < DEPTH_C);

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // PC and in-flight tracking
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            inflight <= 1'b0;
            tag_npc  <= '0;
        end else if (redirect) begin
            // No fetch in the redirect cycle, so nothing arrives next cycle.
            pc       <= EX_MEM_NPC;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc      <= pc_inc;
                tag_npc <= pc_inc;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Fetch buffer pointers and occupancy
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect) begin
            // A pop or push in this cycle does not take effect.
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= ptr_next(tail);
            end
            if (pop) begin
                head <= ptr_next(head);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Fetch buffer storage. It is reset so that the outputs are never X.
    // A redirect leaves the stale contents in place because they are hidden
    // behind count == 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_npc[i]   <= '0;
            end
        end else if (push && !redirect) begin
            fifo_instr[tail] <= imem_rdata;
            fifo_npc[tail]   <= tag_npc;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating redirect counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redir_cnt <= '0;
        end else if (redirect && (redir_cnt != 16'hFFFF)) begin
            redir_cnt <= redir_cnt + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_req       = issue;
    assign imem_addr      = pc[ADDR_W-1:0];
    assign IF_ID_VALID    = (count != '0);
    assign IF_ID_INSTR    = fifo_instr[head];
    assign IF_ID_NPC      = fifo_npc[head];
    assign redirect_count = redir_cnt;

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Directed bench for if_fetch_stage. Two instances are used: u_dut keeps the
// default parameters, and u_wrap uses RESET_PC=0x7F to exercise address
// wrap-around. The memory model is a one-cycle-latency ROM holding
// word k = k*0x11. Inputs change 1 time unit after the rising edge, and
// outputs are checked on the falling edge. Each loop of the cycle task is
// therefore one clock cycle with fixed inputs.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

    // ---------------------------------------------------------------- clock
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT (defaults)
    logic        rst_n;
    logic        pcsrc;
    logic [31:0] npc_in;
    logic        imem_req;
    logic [6:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        id_ready;
    logic        v;
    logic [31:0] instr;
    logic [31:0] npc;
    logic [15:0] rc;

    if_fetch_stage u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .EX_MEM_PCSrc   (pcsrc),
        .EX_MEM_NPC     (npc_in),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_ready       (id_ready),
        .IF_ID_VALID    (v),
        .IF_ID_INSTR    (instr),
        .IF_ID_NPC      (npc),
        .redirect_count (rc)
    );

    // ---------------------------------------------------------------- DUT (wrap)
    logic        w_rst_n;
    logic        w_req;
    logic [6:0]  w_addr;
    logic [31:0] w_rdata;
    logic        w_v;
    logic [31:0] w_instr;
    logic [31:0] w_npc;
    logic [15:0] w_rc;
    logic        w_pcsrc = 1'b0;
    logic [31:0] w_npc_in = 32'h0;
    logic        w_ready = 1'b1;

    if_fetch_stage #(.RESET_PC(32'h7F)) u_wrap (
        .clk            (clk),
        .rst_n          (w_rst_n),
        .EX_MEM_PCSrc   (w_pcsrc),
        .EX_MEM_NPC     (w_npc_in),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_rdata     (w_rdata),
        .id_ready       (w_ready),
        .IF_ID_VALID    (w_v),
        .IF_ID_INSTR    (w_instr),
        .IF_ID_NPC      (w_npc),
        .redirect_count (w_rc)
    );

    // ---------------------------------------------------------------- memory model
    function automatic logic [31:0] mem_word(input logic [6:0] a);
        return {25'd0, a} * 32'h11;
    endfunction

    // Garbage is returned when there is no request, so that a spurious push
    // shows up as a wrong instruction.
    initial imem_rdata = 32'h0;
    initial w_rdata    = 32'h0;
    always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    always @(posedge clk) w_rdata    <= w_req    ? mem_word(w_addr)    : 32'hDEAD_BEEF;

    // ---------------------------------------------------------------- bookkeeping
    int          n_vec = 0;
    int          n_err = 0;
    logic [6:0]  exp_k;

    // One clock cycle with the given inputs; returns at the falling edge.
    task automatic cyc(input logic rdy, input logic sel, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        id_ready = rdy;
        pcsrc    = sel;
        npc_in   = tgt;
        @(negedge clk);
    endtask

    // Expect the head to be word exp_k, then advance exp_k.
    task automatic consume(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            n_vec++;
            if (v !== 1'b1) begin
                n_err++;
                $display("FAIL %s_valid k=%0h got=%b exp=1", tag, exp_k, v);
            end
            n_vec++;
            if (instr !== mem_word(exp_k)) begin
                n_err++;
                $display("FAIL %s_instr k=%0h got=%h exp=%h", tag, exp_k, instr, mem_word(exp_k));
            end
            n_vec++;
            if (npc !== {25'd0, exp_k} + 32'd1) begin
                n_err++;
                $display("FAIL %s_npc k=%0h got=%h exp=%h", tag, exp_k, npc, {25'd0, exp_k} + 32'd1);
            end
            exp_k = exp_k + 7'd1;
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0; w_rst_n = 1'b0;
        id_ready = 1'b1; pcsrc = 1'b0; npc_in = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (v !== 1'b0)         begin n_err++; $display("FAIL reset_valid got=%b exp=0", v); end
        n_vec++; if (instr !== 32'h0)    begin n_err++; $display("FAIL reset_instr got=%h exp=0", instr); end
        n_vec++; if (npc !== 32'h0)      begin n_err++; $display("FAIL reset_npc got=%h exp=0", npc); end
        n_vec++; if (imem_req !== 1'b0)  begin n_err++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        n_vec++; if (rc !== 16'h0)       begin n_err++; $display("FAIL reset_rc got=%h exp=0", rc); end
        n_vec++; if (w_v !== 1'b0)       begin n_err++; $display("FAIL reset_wrap_valid got=%b exp=0", w_v); end
    endtask

    task automatic test_stream();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        // cycle 0: first fetch at RESET_PC
        n_vec++; if (imem_req !== 1'b1)  begin n_err++; $display("FAIL stream_req0 got=%b exp=1", imem_req); end
        n_vec++; if (imem_addr !== 7'h0) begin n_err++; $display("FAIL stream_addr0 got=%h exp=0", imem_addr); end
        n_vec++; if (v !== 1'b0)         begin n_err++; $display("FAIL stream_valid0 got=%b exp=0", v); end
        // cycle 1: data returning, head not yet valid
        cyc(1'b1, 1'b0, 32'h0);
        n_vec++; if (v !== 1'b0)         begin n_err++; $display("FAIL stream_valid1 got=%b exp=0", v); end
        n_vec++; if (imem_addr !== 7'h1) begin n_err++; $display("FAIL stream_addr1 got=%h exp=1", imem_addr); end
        // cycle 2 onward: one instruction per cycle
        exp_k = 7'h0;
        consume("stream", 8);
    endtask

    task automatic test_stall();
        logic [6:0] held;
        held = exp_k;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            n_vec++; if (v !== 1'b1)               begin n_err++; $display("FAIL stall_valid i=%0d got=%b exp=1", i, v); end
            n_vec++; if (instr !== mem_word(held)) begin n_err++; $display("FAIL stall_instr i=%0d got=%h exp=%h", i, instr, mem_word(held)); end
            n_vec++; if (npc !== {25'd0, held} + 32'd1) begin n_err++; $display("FAIL stall_npc i=%0d got=%h exp=%h", i, npc, {25'd0, held} + 32'd1); end
            n_vec++; if (imem_req !== 1'b0)        begin n_err++; $display("FAIL stall_req i=%0d got=%b exp=0", i, imem_req); end
        end
        consume("release", 6);
    endtask

    task automatic test_redirect_full();
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        // buffer is full now; redirect in this cycle
        cyc(1'b0, 1'b1, 32'h40);
        n_vec++; if (imem_req !== 1'b0)   begin n_err++; $display("FAIL rfull_req got=%b exp=0", imem_req); end
        cyc(1'b1, 1'b0, 32'h0);
        n_vec++; if (v !== 1'b0)          begin n_err++; $display("FAIL rfull_valid1 got=%b exp=0", v); end
        n_vec++; if (imem_req !== 1'b1)   begin n_err++; $display("FAIL rfull_req1 got=%b exp=1", imem_req); end
        n_vec++; if (imem_addr !== 7'h40) begin n_err++; $display("FAIL rfull_addr1 got=%h exp=40", imem_addr); end
        cyc(1'b1, 1'b0, 32'h0);
        n_vec++; if (v !== 1'b0)          begin n_err++; $display("FAIL rfull_valid2 got=%b exp=0", v); end
        exp_k = 7'h40;
        consume("rfull", 3);
        n_vec++; if (rc !== 16'd1)        begin n_err++; $display("FAIL rfull_rc got=%0d exp=1", rc); end
    endtask

    task automatic test_redirect_inflight();
        // steady stream: head valid and a response in flight
        cyc(1'b1, 1'b1, 32'h10);
        n_vec++; if (imem_req !== 1'b0)   begin n_err++; $display("FAIL rinf_req got=%b exp=0", imem_req); end
        cyc(1'b1, 1'b0, 32'h0);
        n_vec++; if (v !== 1'b0)          begin n_err++; $display("FAIL rinf_valid1 got=%b exp=0", v); end
        n_vec++; if (imem_addr !== 7'h10) begin n_err++; $display("FAIL rinf_addr1 got=%h exp=10", imem_addr); end
        cyc(1'b1, 1'b0, 32'h0);
        n_vec++; if (v !== 1'b0)          begin n_err++; $display("FAIL rinf_valid2 got=%b exp=0", v); end
        exp_k = 7'h10;
        consume("rinf", 3);
        n_vec++; if (rc !== 16'd2)        begin n_err++; $display("FAIL rinf_rc got=%0d exp=2", rc); end
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 1'b1, 32'h20);
        n_vec++; if (imem_req !== 1'b0)   begin n_err++; $display("FAIL b2b_req0 got=%b exp=0", imem_req); end
        cyc(1'b1, 1'b1, 32'h30);
        n_vec++; if (imem_req !== 1'b0)   begin n_err++; $display("FAIL b2b_req1 got=%b exp=0", imem_req); end
        n_vec++; if (v !== 1'b0)          begin n_err++; $display("FAIL b2b_valid1 got=%b exp=0", v); end
        cyc(1'b1, 1'b0, 32'h0);
        n_vec++; if (v !== 1'b0)          begin n_err++; $display("FAIL b2b_valid2 got=%b exp=0", v); end
        n_vec++; if (imem_addr !== 7'h30) begin n_err++; $display("FAIL b2b_addr got=%h exp=30", imem_addr); end
        cyc(1'b1, 1'b0, 32'h0);
        n_vec++; if (v !== 1'b0)          begin n_err++; $display("FAIL b2b_valid3 got=%b exp=0", v); end
        exp_k = 7'h30;
        consume("b2b", 3);
        n_vec++; if (rc !== 16'd4)        begin n_err++; $display("FAIL b2b_rc got=%0d exp=4", rc); end
    endtask

    task automatic test_async_reset();
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        n_vec++; if (v !== 1'b1)          begin n_err++; $display("FAIL areset_full got=%b exp=1", v); end
        // reset asserted between clock edges
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (v !== 1'b0)          begin n_err++; $display("FAIL areset_valid got=%b exp=0", v); end
        n_vec++; if (instr !== 32'h0)     begin n_err++; $display("FAIL areset_instr got=%h exp=0", instr); end
        n_vec++; if (npc !== 32'h0)       begin n_err++; $display("FAIL areset_npc got=%h exp=0", npc); end
        n_vec++; if (imem_req !== 1'b0)   begin n_err++; $display("FAIL areset_req got=%b exp=0", imem_req); end
        n_vec++; if (rc !== 16'h0)        begin n_err++; $display("FAIL areset_rc got=%h exp=0", rc); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        id_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (imem_req !== 1'b1)   begin n_err++; $display("FAIL areset_req0 got=%b exp=1", imem_req); end
        n_vec++; if (imem_addr !== 7'h0)  begin n_err++; $display("FAIL areset_addr0 got=%h exp=0", imem_addr); end
        cyc(1'b1, 1'b0, 32'h0);
        n_vec++; if (v !== 1'b0)          begin n_err++; $display("FAIL areset_valid1 got=%b exp=0", v); end
        exp_k = 7'h0;
        consume("restart", 2);
    endtask

    task automatic test_addr_wrap();
        @(posedge clk);
        #1 w_rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (w_req !== 1'b1)      begin n_err++; $display("FAIL wrap_req0 got=%b exp=1", w_req); end
        n_vec++; if (w_addr !== 7'h7F)    begin n_err++; $display("FAIL wrap_addr0 got=%h exp=7f", w_addr); end
        cyc(1'b1, 1'b0, 32'h0);
        n_vec++; if (w_addr !== 7'h00)    begin n_err++; $display("FAIL wrap_addr1 got=%h exp=00", w_addr); end
        n_vec++; if (w_req !== 1'b1)      begin n_err++; $display("FAIL wrap_req1 got=%b exp=1", w_req); end
        cyc(1'b1, 1'b0, 32'h0);
        n_vec++; if (w_v !== 1'b1)        begin n_err++; $display("FAIL wrap_valid got=%b exp=1", w_v); end
        n_vec++; if (w_instr !== 32'h86F) begin n_err++; $display("FAIL wrap_instr0 got=%h exp=86f", w_instr); end
        n_vec++; if (w_npc !== 32'h80)    begin n_err++; $display("FAIL wrap_npc0 got=%h exp=80", w_npc); end
        cyc(1'b1, 1'b0, 32'h0);
        n_vec++; if (w_instr !== 32'h0)   begin n_err++; $display("FAIL wrap_instr1 got=%h exp=0", w_instr); end
        n_vec++; if (w_npc !== 32'h81)    begin n_err++; $display("FAIL wrap_npc1 got=%h exp=81", w_npc); end
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_redirect_inflight();
        test_back_to_back();
        test_async_reset();
        test_addr_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
